// File: rtl/checkout_sequencer.sv
// Checkout pass over basket storage: reads each occupied slot, prices it, emits
// line items over a valid/ready handshake and then presents the saturating total.
module checkout_sequencer #(
  parameter int MAX_ITEMS = 12,
  parameter int PRICE_W   = 8,
  parameter int TOTAL_W   = 12
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 Start_Pulse,
  input  logic                 Abort_Pulse,
  input  logic [3:0]           BasketProductNum,
  output logic                 Basket_RdEn,
  output logic [3:0]           Basket_RdAddr,
  input  logic [3:0]           Basket_RdProductID,
  input  logic [3:0]           Basket_RdQuantity,
  output logic [3:0]           Price_ProductID,
  input  logic [PRICE_W-1:0]   Price_Value,
  output logic                 Line_Valid,
  input  logic                 Line_Ready,
  output logic [3:0]           Line_Index,
  output logic [3:0]           Line_ProductID,
  output logic [3:0]           Line_Quantity,
  output logic [PRICE_W+3:0]   Line_Subtotal,
  output logic [TOTAL_W-1:0]   Total,
  output logic                 Total_Valid,
  output logic                 Overflow,
  output logic                 Busy,
  output logic                 Done_Pulse
);

  localparam int         SUB_W = PRICE_W + 4;
  localparam logic [3:0] MAX_N = 4'(MAX_ITEMS);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, EMIT, FINISH} state_t;

  state_t           state;
  logic [3:0]       n_q;
  logic [3:0]       slot_q;
  logic [3:0]       id_q;
  logic [3:0]       qty_q;
  logic [3:0]       n_start;
  logic [3:0]       slot_next;
  logic             last_slot;
  logic [SUB_W-1:0] subtotal;
  logic [TOTAL_W:0] sum;

  assign n_start   = (BasketProductNum > MAX_N) ? MAX_N : BasketProductNum;
  assign slot_next = slot_q + 4'd1;
  assign last_slot = (slot_next == n_q);

  assign Price_ProductID = id_q;
  // Full-width product: 8-bit price times 4-bit quantity always fits in SUB_W.
  assign subtotal = SUB_W'(Price_Value) * SUB_W'(qty_q);
  assign sum      = (TOTAL_W+1)'(Total) + (TOTAL_W+1)'(subtotal);

  assign Busy = (state != IDLE);

  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; the reset branch clears control and datapath alike.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= IDLE;
      n_q            <= '0;
      slot_q         <= '0;
      id_q           <= '0;
      qty_q          <= '0;
      Basket_RdEn    <= 1'b0;
      Basket_RdAddr  <= '0;
      Line_Valid     <= 1'b0;
      Line_Index     <= '0;
      Line_ProductID <= '0;
      Line_Quantity  <= '0;
      Line_Subtotal  <= '0;
      Total          <= '0;
      Total_Valid    <= 1'b0;
      Overflow       <= 1'b0;
      Done_Pulse     <= 1'b0;
    end else begin
      // NOTE: strobes default low here so each one lasts exactly one cycle.
      Basket_RdEn <= 1'b0;
      Done_Pulse  <= 1'b0;
      if (Abort_Pulse) begin
        state       <= IDLE;
        Line_Valid  <= 1'b0;
        Total_Valid <= 1'b0;
        Total       <= '0;
      end else begin
        case (state)
          IDLE: if (Start_Pulse) begin
            n_q         <= n_start;
            Total       <= '0;
            Overflow    <= 1'b0;
            Total_Valid <= 1'b0;
            slot_q      <= '0;
            Line_Index  <= '0;
            if (n_start == 4'd0) begin
              state <= FINISH;
            end else begin
              state         <= READ;
              Basket_RdEn   <= 1'b1;
              Basket_RdAddr <= '0;
            end
          end
          READ: state <= WAIT;
          WAIT: begin
            id_q  <= Basket_RdProductID;
            qty_q <= Basket_RdQuantity;
            if (Basket_RdQuantity == 4'd0) begin
              slot_q <= slot_next;
              if (last_slot) begin
                state <= FINISH;
              end else begin
                state         <= READ;
                Basket_RdEn   <= 1'b1;
                Basket_RdAddr <= slot_next;
              end
            end else begin
              state <= CALC;
            end
          end
          CALC: begin
            Line_Subtotal  <= subtotal;
            Line_ProductID <= id_q;
            Line_Quantity  <= qty_q;
            if (sum[TOTAL_W]) begin
              Total    <= '1;
              Overflow <= 1'b1;
            end else begin
              Total <= sum[TOTAL_W-1:0];
            end
            Line_Valid <= 1'b1;
            state      <= EMIT;
          end
          EMIT: if (Line_Valid && Line_Ready) begin
            Line_Valid <= 1'b0;
            Line_Index <= Line_Index + 4'd1;
            slot_q     <= slot_next;
            if (last_slot) begin
              state <= FINISH;
            end else begin
              state         <= READ;
              Basket_RdEn   <= 1'b1;
              Basket_RdAddr <= slot_next;
            end
          end
          FINISH: begin
            Total_Valid <= 1'b1;
            Done_Pulse  <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_checkout_sequencer.sv
// Scoreboard bench for checkout_sequencer: stimulus pushes expected lines and
// totals; a negedge monitor pops and compares on each handshake and Done_Pulse.
module tb_checkout_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        Start_Pulse = 1'b0;
  logic        Abort_Pulse = 1'b0;
  logic [3:0]  BasketProductNum = '0;
  logic        Basket_RdEn;
  logic [3:0]  Basket_RdAddr;
  logic [3:0]  Basket_RdProductID = '0;
  logic [3:0]  Basket_RdQuantity = '0;
  logic [3:0]  Price_ProductID;
  logic [7:0]  Price_Value;
  logic        Line_Valid;
  logic        Line_Ready = 1'b1;
  logic [3:0]  Line_Index;
  logic [3:0]  Line_ProductID;
  logic [3:0]  Line_Quantity;
  logic [11:0] Line_Subtotal;
  logic [11:0] Total;
  logic        Total_Valid;
  logic        Overflow;
  logic        Busy;
  logic        Done_Pulse;

  checkout_sequencer #(.MAX_ITEMS(12), .PRICE_W(8), .TOTAL_W(12)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .Start_Pulse(Start_Pulse), .Abort_Pulse(Abort_Pulse),
    .BasketProductNum(BasketProductNum),
    .Basket_RdEn(Basket_RdEn), .Basket_RdAddr(Basket_RdAddr),
    .Basket_RdProductID(Basket_RdProductID), .Basket_RdQuantity(Basket_RdQuantity),
    .Price_ProductID(Price_ProductID), .Price_Value(Price_Value),
    .Line_Valid(Line_Valid), .Line_Ready(Line_Ready), .Line_Index(Line_Index),
    .Line_ProductID(Line_ProductID), .Line_Quantity(Line_Quantity),
    .Line_Subtotal(Line_Subtotal), .Total(Total), .Total_Valid(Total_Valid),
    .Overflow(Overflow), .Busy(Busy), .Done_Pulse(Done_Pulse)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {int idx; int id; int qty; int sub; int total; int ov; int cyc;} line_t;
  typedef struct {int total; int ov; int cyc;} done_t;

  line_t exp_lines[$];
  done_t exp_done[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rd_count = 0;
  bit allow_drop = 1'b0;

  logic [3:0] b_id [16];
  logic [3:0] b_qty[16];
  logic [7:0] price[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Basket storage and price table models.
  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (Basket_RdEn) begin
      Basket_RdProductID <= b_id[Basket_RdAddr];
      Basket_RdQuantity  <= b_qty[Basket_RdAddr];
    end else begin
      Basket_RdProductID <= 4'hF;
      Basket_RdQuantity  <= 4'hF;
    end
  end
  assign Price_Value = price[Price_ProductID];

  logic        hold_v = 1'b0;
  logic [23:0] hold_fields = '0;

  always @(negedge CLOCK_50) begin
    if (RESET_N) begin
      if (Basket_RdEn) rd_count <= rd_count + 1;
      if (hold_v && !allow_drop) check("line_valid_held", 32'(Line_Valid), 1);
      if (hold_v && Line_Valid)
        check("line_fields_stable", 32'({Line_Index, Line_ProductID, Line_Quantity, Line_Subtotal}),
              32'(hold_fields));
      if (Line_Valid && Line_Ready) begin
        if (exp_lines.size() == 0) begin
          fail("unexpected_line");
        end else begin
          check("line_index",    32'(Line_Index),     exp_lines[0].idx);
          check("line_id",       32'(Line_ProductID), exp_lines[0].id);
          check("line_qty",      32'(Line_Quantity),  exp_lines[0].qty);
          check("line_subtotal", 32'(Line_Subtotal),  exp_lines[0].sub);
          check("line_total",    32'(Total),          exp_lines[0].total);
          check("line_overflow", 32'(Overflow),       exp_lines[0].ov);
          check("line_cycle",    cyc,                 exp_lines[0].cyc);
          void'(exp_lines.pop_front());
        end
      end
      if (Done_Pulse) begin
        if (exp_done.size() == 0) begin
          fail("unexpected_done");
        end else begin
          check("done_total",    32'(Total),       exp_done[0].total);
          check("done_overflow", 32'(Overflow),    exp_done[0].ov);
          check("done_tvalid",   32'(Total_Valid), 1);
          check("done_busy",     32'(Busy),        0);
          check("done_cycle",    cyc,              exp_done[0].cyc);
          void'(exp_done.pop_front());
        end
      end
      hold_v      <= Line_Valid && !Line_Ready;
      hold_fields <= {Line_Index, Line_ProductID, Line_Quantity, Line_Subtotal};
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_line(input int idx, input int id, input int qty, input int sub,
                           input int total, input int ov, input int c);
    line_t e;
    e = '{idx, id, qty, sub, total, ov, c};
    exp_lines.push_back(e);
  endtask

  task automatic push_done(input int total, input int ov, input int c);
    done_t e;
    e = '{total, ov, c};
    exp_done.push_back(e);
  endtask

  task automatic pulse_start();
    Start_Pulse = 1'b1;
    tick();
    Start_Pulse = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((exp_lines.size() != 0 || exp_done.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (exp_lines.size() != 0 || exp_done.size() != 0) begin
      fail({name, "_timeout"});
      exp_lines.delete();
      exp_done.delete();
    end
    tick(2);
  endtask

  task automatic clear_basket();
    for (int i = 0; i < 16; i++) begin
      b_id[i]  = 4'd0;
      b_qty[i] = 4'd0;
    end
  endtask

  task automatic basket_two();
    clear_basket();
    b_id[0] = 4'd3; b_qty[0] = 4'd2;
    b_id[1] = 4'd5; b_qty[1] = 4'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s;
    int r0;
    for (int i = 0; i < 16; i++) price[i] = 8'd0;
    price[3] = 8'd25;
    price[5] = 8'd40;
    price[7] = 8'd17;
    price[9] = 8'd255;
    clear_basket();

    // Reset state.
    tick(3);
    check("rst_line_valid",  32'(Line_Valid),    0);
    check("rst_total_valid", 32'(Total_Valid),   0);
    check("rst_busy",        32'(Busy),          0);
    check("rst_done",        32'(Done_Pulse),    0);
    check("rst_rden",        32'(Basket_RdEn),   0);
    check("rst_total",       32'(Total),         0);
    check("rst_overflow",    32'(Overflow),      0);
    check("rst_line_index",  32'(Line_Index),    0);
    check("rst_subtotal",    32'(Line_Subtotal), 0);
    RESET_N = 1'b1;
    tick(2);

    // Two-line basket, ready high; a mid-pass start and count change are ignored.
    basket_two();
    BasketProductNum = 4'd2;
    Line_Ready = 1'b1;
    s = cyc;
    push_line(0, 3, 2, 50, 50, 0, s + 4);
    push_line(1, 5, 1, 40, 90, 0, s + 8);
    push_done(90, 0, s + 10);
    pulse_start();
    tick();
    check("busy_running", 32'(Busy), 1);
    Start_Pulse = 1'b1;
    BasketProductNum = 4'd7;
    tick();
    Start_Pulse = 1'b0;
    wait_idle("basic", 40);
    check("total_hold",        32'(Total),       90);
    check("total_valid_hold",  32'(Total_Valid), 1);

    // Same basket, line 0 stalled for five cycles.
    BasketProductNum = 4'd2;
    Line_Ready = 1'b0;
    s = cyc;
    push_line(0, 3, 2, 50, 50, 0, s + 9);
    push_line(1, 5, 1, 40, 90, 0, s + 13);
    push_done(90, 0, s + 15);
    pulse_start();
    tick(8);
    Line_Ready = 1'b1;
    wait_idle("stall", 40);

    // Empty basket: no reads, done two cycles after start.
    BasketProductNum = 4'd0;
    r0 = rd_count;
    s = cyc;
    push_done(0, 0, s + 2);
    pulse_start();
    wait_idle("empty", 20);
    check("empty_no_reads", rd_count, r0);

    // Zero-quantity slot in the middle is skipped in two cycles.
    clear_basket();
    b_id[0] = 4'd3; b_qty[0] = 4'd2;
    b_id[1] = 4'd5; b_qty[1] = 4'd0;
    b_id[2] = 4'd7; b_qty[2] = 4'd3;
    BasketProductNum = 4'd3;
    s = cyc;
    push_line(0, 3, 2, 50, 50, 0, s + 4);
    push_line(1, 7, 3, 51, 101, 0, s + 10);
    push_done(101, 0, s + 12);
    pulse_start();
    wait_idle("skip", 40);

    // Saturation: 3 x 3825 clips at 4095 from the second line on.
    clear_basket();
    for (int i = 0; i < 3; i++) begin
      b_id[i]  = 4'd9;
      b_qty[i] = 4'd15;
    end
    s = cyc;
    push_line(0, 9, 15, 3825, 3825, 0, s + 4);
    push_line(1, 9, 15, 3825, 4095, 1, s + 8);
    push_line(2, 9, 15, 3825, 4095, 1, s + 12);
    push_done(4095, 1, s + 14);
    pulse_start();
    wait_idle("overflow", 40);

    // Count 15 clamps to 12 slots; slot 12 must never be read.
    clear_basket();
    b_id[11] = 4'd5; b_qty[11] = 4'd1;
    b_id[12] = 4'd3; b_qty[12] = 4'd5;
    BasketProductNum = 4'd15;
    s = cyc;
    push_line(0, 5, 1, 40, 40, 0, s + 26);
    push_done(40, 0, s + 28);
    pulse_start();
    wait_idle("clamp", 60);

    // Abort with simultaneous start while line 1 is waiting, then a clean restart.
    basket_two();
    BasketProductNum = 4'd2;
    Line_Ready = 1'b1;
    s = cyc;
    push_line(0, 3, 2, 50, 50, 0, s + 4);
    pulse_start();
    tick(4);
    Line_Ready = 1'b0;
    tick(4);
    check("abort_pre_valid", 32'(Line_Valid), 1);
    allow_drop  = 1'b1;
    Abort_Pulse = 1'b1;
    Start_Pulse = 1'b1;
    tick();
    Abort_Pulse = 1'b0;
    Start_Pulse = 1'b0;
    check("abort_line_valid",  32'(Line_Valid),  0);
    check("abort_total_valid", 32'(Total_Valid), 0);
    check("abort_busy",        32'(Busy),        0);
    check("abort_total",       32'(Total),       0);
    tick(4);
    allow_drop = 1'b0;
    check("abort_lines_left", exp_lines.size(), 0);
    check("abort_still_idle", 32'(Busy), 0);
    Line_Ready = 1'b1;
    s = cyc;
    push_line(0, 3, 2, 50, 50, 0, s + 4);
    push_line(1, 5, 1, 40, 90, 0, s + 8);
    push_done(90, 0, s + 10);
    pulse_start();
    wait_idle("restart", 40);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/checkout_sequencer.md
Name: checkout_sequencer

Overview:
- Runs the end-of-shopping pass over basket storage: reads each occupied slot, looks up its unit price, forms line subtotals and accumulates the basket total.
- Presents each line item to the display/receipt side over a valid/ready handshake, then presents the total.
- Sits between the main state machine (start/abort pulses), the basket storage read port, the price table and the display controller.

Parameters:
MAX_ITEMS, 12, number of basket slots; a BasketProductNum above this is clamped to it
PRICE_W, 8, unit price width
TOTAL_W, 12, accumulated total width; subtotal width is PRICE_W+4

Ports:
CLOCK_50  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
Start_Pulse  in  1  one-cycle checkout request from the state machine
Abort_Pulse  in  1  one-cycle cancel request
BasketProductNum  in  4  occupied slot count
Basket_RdEn  out  1  basket read strobe
Basket_RdAddr  out  4  basket slot index
Basket_RdProductID  in  4  slot product ID, valid 1 cycle after Basket_RdEn
Basket_RdQuantity  in  4  slot quantity, valid 1 cycle after Basket_RdEn
Price_ProductID  out  4  price table address
Price_Value  in  PRICE_W  unit price, combinational from Price_ProductID
Line_Valid  out  1  line item available
Line_Ready  in  1  display accepts line
Line_Index  out  4  emitted line number, starting at 0
Line_ProductID  out  4  line product
Line_Quantity  out  4  line quantity
Line_Subtotal  out  PRICE_W+4  price*quantity
Total  out  TOTAL_W  accumulated total
Total_Valid  out  1  Total is final
Overflow  out  1  sticky: total saturated
Busy  out  1  high in every state except IDLE
Done_Pulse  out  1  one cycle at completion

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; slot index and line counter 0.
- States: IDLE, READ, WAIT, CALC, EMIT, FINISH.
- IDLE:
  - On Start_Pulse, latch N = min(BasketProductNum, MAX_ITEMS); clear Total, Overflow, Total_Valid and the slot/line counters.
  - If N = 0, go to FINISH; otherwise go to READ.
- READ: Basket_RdEn=1 and Basket_RdAddr=slot for exactly one cycle; go to WAIT.
- WAIT: register ProductID and Quantity.
  - If Quantity = 0, the slot is skipped: increment slot, then go to FINISH if slot+1 = N, else READ.
  - Otherwise go to CALC.
- CALC:
  - Drive Price_ProductID from the latched ID.
  - Register Line_Subtotal = Price_Value*Quantity at full PRICE_W+4 width, with no truncation.
  - Total <= Total + subtotal. If the sum exceeds 2^TOTAL_W-1, Total saturates to all ones and Overflow is set (sticky).
  - Go to EMIT.
- EMIT:
  - Line_Valid=1. Line_Index, Line_ProductID, Line_Quantity and Line_Subtotal are held stable until the handshake.
  - Handshake = Line_Valid & Line_Ready, in the same cycle. On it: Line_Valid drops next cycle, line and slot counters increment, and the next state is FINISH if slot+1 = N, else READ.
  - Line_Valid never drops without a handshake, except on abort.
- FINISH:
  - Total_Valid=1 and Done_Pulse=1 for one cycle; go to IDLE.
  - Total and Total_Valid hold until the next accepted Start_Pulse or an Abort_Pulse.
- Latency, per slot with Line_Ready held high: 4 cycles (READ, WAIT, CALC, EMIT). Skipped slot: 2 cycles.
- Abort_Pulse, in any state:
  - Next state IDLE.
  - Line_Valid, Total_Valid, Basket_RdEn and Busy go to 0; Total goes to 0.
  - No Done_Pulse.
  - Abort wins over a simultaneous Start_Pulse.
- Start_Pulse while Busy: ignored.
- BasketProductNum changes during a pass: ignored, since N was latched at start.
- Busy = (state != IDLE).

Test Plan:
- Basket {slot0: ID3 qty2, slot1: ID5 qty1}, price(3)=25, price(5)=40, Line_Ready tied high, Start_Pulse -> two lines: (0,3,2,50) then (1,5,1,40); Total=90; Total_Valid=1; one Done_Pulse; Overflow=0; each line emitted 4 cycles after the previous.
- Same basket, Line_Ready held low 5 cycles on line 0 -> Line_Valid and all line fields stable throughout; exactly one acceptance; final Total=90.
- BasketProductNum=0, Start_Pulse -> no Basket_RdEn; Total=0, Total_Valid=1 and Done_Pulse 2 cycles after start.
- Slot1 qty 0 inside a 3-slot basket -> only 2 lines emitted, Line_Index 0 then 1; skipped slot takes 2 cycles.
- TOTAL_W=12, three slots each price 255 qty 15 (3825 each) -> Total=4095, Overflow=1 after the second line and still 1 at Done_Pulse.
- Abort_Pulse asserted during EMIT of line 1, together with a Start_Pulse -> next cycle IDLE, Line_Valid=0, Total_Valid=0, Busy=0, no Done_Pulse. A following Start_Pulse restarts the pass from slot 0 with Total cleared.
